xor_gate_tester: RTL and testbench
==================================

Name: xor_gate_tester

Overview:
Self-checking stimulus sequencer for the quad 2-input XOR gate block (74HC86 equivalent) used in the gate-circuit lab designs. On start it sweeps all 256 combinations of the two 4-bit operands onto the gate inputs. After a programmable settle time it samples the gate outputs and compares them against A XOR B. It reports error count, first failing vector, and pass/done status. It sits on the board beside the gate under test, internal or on external pins, and owns the gate's input buses while running.

Parameters:
SETTLE_CYCLES, 4, clock cycles between driving a vector and sampling y_in; legal range 2..255 (the minimum covers the input synchronizer).

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a sweep when not busy
abort  input  1  one-cycle pulse; terminates a sweep, returns to IDLE
a_out  output  4  operand A driven to the gate under test
b_out  output  4  operand B driven to the gate under test
y_in  input  4  gate outputs, possibly asynchronous (external pins)
busy  output  1  high from the cycle after an accepted start until DONE or IDLE
done  output  1  high in DONE; held until the next start or rst
pass  output  1  valid when done=1; 1 iff err_cnt==0
err_cnt  output  9  number of mismatching vectors in the current/last sweep (0..256)
fail_valid  output  1  1 once the first mismatch is captured
fail_vec  output  8  {a,b} of the first failing vector
fail_y  output  4  sampled y_in of the first failing vector

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, fail_vec=0, fail_y=0, settle counter=0, synchronizer flops=0.
- y_in passes through a 2-flop synchronizer (y_s). All comparisons use y_s.
- Vector index idx is 8 bits. a_out=idx[7:4], b_out=idx[3:0], both registered. Expected value = idx[7:4]^idx[3:0].
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: on start, clear err_cnt, fail_valid, fail_vec, fail_y, pass, done; set idx=0; go to DRIVE.
- DRIVE (1 cycle): a_out/b_out update from idx; load settle counter=SETTLE_CYCLES; go to SETTLE.
- SETTLE: decrement each cycle; go to CHECK when the counter reaches 1. This gives exactly SETTLE_CYCLES cycles in SETTLE.
- CHECK (1 cycle): on y_s != expected, increment err_cnt. If fail_valid=0, capture fail_vec=idx, fail_y=y_s, and set fail_valid=1.
  - If idx==255, go to DONE with pass=(final err_cnt==0) and done=1.
  - Otherwise idx+=1 and go to DRIVE.
- Timing: each vector takes SETTLE_CYCLES+2 cycles; a full sweep takes 256*(SETTLE_CYCLES+2) cycles (1536 at default). done asserts the cycle after the last CHECK.
- DONE: outputs hold; a_out/b_out hold the last vector. start restarts exactly as from IDLE; abort goes to IDLE with done=0 and results kept.
- start while busy: ignored.
- abort while busy: go to IDLE next cycle; busy=0, done=0, pass=0; err_cnt/fail_* retain partial values; a_out/b_out hold.
- start and abort in the same cycle: abort wins.
- rst mid-sweep: immediate return to reset values; no partial result is preserved.
- err_cnt never wraps; the maximum is 256.
- idx wrap from 255 to 0 never occurs inside a sweep.

Test Plan:
1. Ideal gate model (y_in=a_out^b_out), default param, start pulse -> busy=1 for 1536 cycles; then done=1, pass=1, err_cnt=0, fail_valid=0, a_out=F, b_out=F.
2. Gate with y[2] stuck at 0 -> done with pass=0, err_cnt=128, fail_valid=1, fail_vec=0x04, fail_y=0x0.
3. Gate with y[0] inverted -> err_cnt=256, fail_vec=0x00, fail_y=0x1, pass=0.
4. Abort pulsed during vector idx=0x30, then start -> first run ends with busy=0, done=0; second run completes in the full 1536 cycles with err_cnt cleared at start.
5. start re-pulsed during busy, and start+abort in the same cycle -> extra start has no effect on timing or counts; the simultaneous case returns to IDLE.
6. rst asserted mid-sweep (idx=0x80), SETTLE_CYCLES=2 build -> all outputs zero asynchronously; a fresh sweep completes in 1024 cycles with pass=1.

Source files
------------

// File: rtl/xor_gate_tester.sv
// Stimulus sequencer for a quad 2-input XOR gate: sweeps all 256 {a,b} pairs,
// samples the synchronized gate outputs after a settle delay and tallies mismatches.
module xor_gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  input  logic [3:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_cnt,
  output logic       fail_valid,
  output logic [7:0] fail_vec,
  output logic [3:0] fail_y
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t     state;
  logic [7:0] idx;
  logic [7:0] settle_cnt;
  logic [3:0] y_meta;
  logic [3:0] y_s;
  logic [3:0] expected;
  logic       mismatch;
  logic [8:0] err_next;

  // y_in may come from external pins, so it is resynchronized before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_meta <= '0;
      y_s    <= '0;
    end else begin
      y_meta <= y_in;
      y_s    <= y_meta;
    end
  end

  assign expected = idx[7:4] ^ idx[3:0];
  assign mismatch = (y_s != expected);
  // Saturating increment; 256 is only reachable when every vector fails.
  assign err_next = (mismatch && (err_cnt != 9'd256)) ? err_cnt + 9'd1 : err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      a_out      <= '0;
      b_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_y     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (start) begin
            state      <= DRIVE;
            idx        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            fail_y     <= '0;
          end
        end

        DRIVE, SETTLE, CHECK: begin
          if (abort) begin
            // Partial results stay visible; operand buses hold their last value.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            case (state)
              DRIVE: begin
                a_out      <= idx[7:4];
                b_out      <= idx[3:0];
                settle_cnt <= SETTLE_LOAD;
                state      <= SETTLE;
              end
              SETTLE: begin
                if (settle_cnt <= 8'd1) begin
                  state <= CHECK;
                end else begin
                  settle_cnt <= settle_cnt - 8'd1;
                end
              end
              default: begin
                err_cnt <= err_next;
                if (mismatch && !fail_valid) begin
                  fail_valid <= 1'b1;
                  fail_vec   <= idx;
                  fail_y     <= y_s;
                end
                if (idx == 8'hFF) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == 9'd0);
                end else begin
                  idx   <= idx + 8'd1;
                  state <= DRIVE;
                end
              end
            endcase
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_gate_tester.sv
// Directed-vector bench for xor_gate_tester: ideal and faulty gate models,
// abort/restart, redundant start, start+abort collision, async reset mid-sweep.
module tb_xor_gate_tester;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] a_out, b_out, y_in;
  logic       busy, done, pass, fail_valid;
  logic [8:0] err_cnt;
  logic [7:0] fail_vec;
  logic [3:0] fail_y;

  logic       rst2, start2, abort2;
  logic [3:0] a_out2, b_out2, y_in2;
  logic       busy2, done2, pass2, fail_valid2;
  logic [8:0] err_cnt2;
  logic [7:0] fail_vec2;
  logic [3:0] fail_y2;

  int checks = 0;
  int passed = 0;
  int mode   = 0;  // 0 ideal, 1 y[2] stuck at 0, 2 y[0] inverted

  always #5 clk = ~clk;

  always_comb begin
    y_in = a_out ^ b_out;
    if (mode == 1)      y_in[2] = 1'b0;
    else if (mode == 2) y_in[0] = ~y_in[0];
  end
  assign y_in2 = a_out2 ^ b_out2;

  xor_gate_tester dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a_out(a_out), .b_out(b_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_y(fail_y)
  );

  xor_gate_tester #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .abort(abort2),
    .a_out(a_out2), .b_out(b_out2), .y_in(y_in2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .fail_valid(fail_valid2), .fail_vec(fail_vec2), .fail_y(fail_y2)
  );

  // Counts negedges with busy high; caller is at the negedge after the start edge.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 4000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if ({busy, done, pass, fail_valid} !== 4'b0000) $display("FAIL reset_flags got=%b want=0000", {busy, done, pass, fail_valid}); else passed++;
    checks++; if (err_cnt !== 9'd0) $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); else passed++;
    checks++; if ({a_out, b_out, fail_vec, fail_y} !== 20'h0) $display("FAIL reset_data got=%h want=00000", {a_out, b_out, fail_vec, fail_y}); else passed++;
    checks++; if ({busy2, done2, a_out2, b_out2} !== 10'h0) $display("FAIL reset_dut2 got=%h want=0", {busy2, done2, a_out2, b_out2}); else passed++;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_ideal;
    int cyc;
    mode = 0;
    pulse_start();
    checks++; if (busy !== 1'b1) $display("FAIL ideal_busy_rise got=%b want=1", busy); else passed++;
    wait_idle(cyc);
    checks++; if (cyc !== 1536) $display("FAIL ideal_cycles got=%0d want=1536", cyc); else passed++;
    checks++; if ({done, pass, fail_valid} !== 3'b110) $display("FAIL ideal_status got=%b want=110", {done, pass, fail_valid}); else passed++;
    checks++; if (err_cnt !== 9'd0) $display("FAIL ideal_err_cnt got=%0d want=0", err_cnt); else passed++;
    checks++; if ({a_out, b_out} !== 8'hFF) $display("FAIL ideal_last_vec got=%h want=ff", {a_out, b_out}); else passed++;
    $display("ideal: cycles=%0d err_cnt=%0d pass=%b", cyc, err_cnt, pass);
  endtask

  task automatic test_stuck_y2;
    int cyc;
    mode = 1;
    pulse_start();
    wait_idle(cyc);
    checks++; if ({done, pass, fail_valid} !== 3'b101) $display("FAIL stuck_status got=%b want=101", {done, pass, fail_valid}); else passed++;
    checks++; if (err_cnt !== 9'd128) $display("FAIL stuck_err_cnt got=%0d want=128", err_cnt); else passed++;
    checks++; if (fail_vec !== 8'h04) $display("FAIL stuck_fail_vec got=%h want=04", fail_vec); else passed++;
    checks++; if (fail_y !== 4'h0) $display("FAIL stuck_fail_y got=%h want=0", fail_y); else passed++;
    $display("stuck_y2: err_cnt=%0d fail_vec=%h fail_y=%h", err_cnt, fail_vec, fail_y);
  endtask

  task automatic test_invert_y0;
    int cyc;
    mode = 2;
    pulse_start();
    wait_idle(cyc);
    checks++; if (err_cnt !== 9'd256) $display("FAIL inv_err_cnt got=%0d want=256", err_cnt); else passed++;
    checks++; if ({fail_vec, fail_y} !== 12'h001) $display("FAIL inv_fail_info got=%h want=001", {fail_vec, fail_y}); else passed++;
    checks++; if ({done, pass} !== 2'b10) $display("FAIL inv_status got=%b want=10", {done, pass}); else passed++;
    $display("invert_y0: err_cnt=%0d fail_vec=%h fail_y=%h", err_cnt, fail_vec, fail_y);
  endtask

  task automatic test_abort_restart;
    int cyc = 0;
    mode = 1;
    pulse_start();
    while (!(a_out == 4'h3 && b_out == 4'h0) && cyc < 4000) begin
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc >= 4000) $display("FAIL abort_reach_30 got=timeout want=vector 30"); else passed++;
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    // vectors 00..2F were checked: 24 have (a^b)[2] set
    checks++; if ({busy, done, pass} !== 3'b000) $display("FAIL abort_status got=%b want=000", {busy, done, pass}); else passed++;
    checks++; if (err_cnt !== 9'd24) $display("FAIL abort_partial_err got=%0d want=24", err_cnt); else passed++;
    checks++; if ({fail_valid, fail_vec, a_out, b_out} !== 17'h10430) $display("FAIL abort_hold got=%h want=10430", {fail_valid, fail_vec, a_out, b_out}); else passed++;
    mode = 0;
    pulse_start();
    checks++; if ({err_cnt, fail_valid} !== 10'd0) $display("FAIL restart_clear got=%h want=0", {err_cnt, fail_valid}); else passed++;
    wait_idle(cyc);
    checks++; if (cyc !== 1536) $display("FAIL restart_cycles got=%0d want=1536", cyc); else passed++;
    checks++; if ({done, pass, err_cnt} !== {2'b11, 9'd0}) $display("FAIL restart_result got=%b want=11000000000", {done, pass, err_cnt}); else passed++;
    $display("abort_restart: second run cycles=%0d err_cnt=%0d", cyc, err_cnt);
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    mode = 0;
    pulse_start();
    while (busy && cyc < 4000) begin
      cyc++;
      start = (cyc == 100);
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (cyc !== 1536) $display("FAIL restart_ignored_cycles got=%0d want=1536", cyc); else passed++;
    checks++; if ({done, pass, err_cnt} !== {2'b11, 9'd0}) $display("FAIL restart_ignored_result got=%b want=11000000000", {done, pass, err_cnt}); else passed++;
    pulse_start();
    repeat (50) @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    checks++; if ({busy, done} !== 2'b00) $display("FAIL start_abort_busy got=%b want=00", {busy, done}); else passed++;
    start = 1'b1; abort = 1'b1;
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    checks++; if (busy !== 1'b0) $display("FAIL start_abort_idle got=%b want=0", busy); else passed++;
    $display("back_to_back: extra start ignored, start+abort returns idle");
  endtask

  task automatic test_async_reset;
    int cyc = 0;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    while (!(a_out2 == 4'h8 && b_out2 == 4'h0) && cyc < 4000) begin
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc >= 4000) $display("FAIL rst_reach_80 got=timeout want=vector 80"); else passed++;
    #2 rst2 = 1'b1;
    #1;
    checks++; if ({busy2, done2, pass2, fail_valid2, err_cnt2, a_out2, b_out2} !== 21'h0) $display("FAIL async_rst_outputs got=%h want=0", {busy2, done2, pass2, fail_valid2, err_cnt2, a_out2, b_out2}); else passed++;
    @(negedge clk) rst2 = 1'b0;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 4000) begin
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc !== 1024) $display("FAIL settle2_cycles got=%0d want=1024", cyc); else passed++;
    checks++; if ({done2, pass2, err_cnt2} !== {2'b11, 9'd0}) $display("FAIL settle2_result got=%b want=11000000000", {done2, pass2, err_cnt2}); else passed++;
    $display("async_reset: fresh sweep cycles=%0d pass=%b", cyc, pass2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    rst2 = 1'b1; start2 = 1'b0; abort2 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0; rst2 = 1'b0;
    test_ideal();
    test_stuck_y2();
    test_invert_y0();
    test_abort_restart();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
